ballot_collector: RTL

- Upstream stage of the four-person voter: runs one voting session at a time and collects one yes/no ballot per voter from button inputs.
- Freezes the collected ballot and drives the 4-bit vote vector into the voter's I input.
- Flags when that vector is final, so downstream majority logic only ever sees a settled ballot.

---
 rtl/ballot_pkg.sv | 14 +
 rtl/ballot_collector_btn_edge_det.sv | 21 ++
 rtl/ballot_collector.sv | 118 +++++++++++
 3 files changed

// File: rtl/ballot_pkg.sv
// Shared types for the ballot collector: session state and the per-voter vote vector.
package ballot_pkg;

   localparam int N_VOTERS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [N_VOTERS-1:0] vote_t;

endpackage

// File: rtl/ballot_collector_btn_edge_det.sv
// Rising-edge detector for a bank of level buttons; the history register tracks
// the input every cycle so a button held across a state change never fires late.
module btn_edge_det #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_lvl,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= '0;
      else     r_q <= i_lvl;
   end

   assign o_rise = i_lvl & ~r_q;

endmodule

// File: rtl/ballot_collector.sv
// Collects one yes/no ballot per voter per session and presents a frozen vote vector.
// Build option: define REVOTE_EN to allow ballot changes while open and disable auto-close.
module ballot_collector #(
   parameter int N_VOTERS       = ballot_pkg::N_VOTERS,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                close_i,
   input  logic [N_VOTERS-1:0] btn_yes_i,
   input  logic [N_VOTERS-1:0] btn_no_i,
   output logic [N_VOTERS-1:0] votes_o,
   output logic [N_VOTERS-1:0] cast_o,
   output logic                open_o,
   output logic                valid_o,
   output logic                timeout_o
);
   import ballot_pkg::*;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state, w_state_nxt;
   logic [N_VOTERS-1:0] r_votes, w_votes_nxt;
   logic [N_VOTERS-1:0] r_cast, w_cast_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_timeout, w_timeout_nxt;

   logic [N_VOTERS-1:0] w_yes_rise, w_no_rise;
   logic [N_VOTERS-1:0] w_yes_ok, w_no_ok, w_rec;
   logic [N_VOTERS-1:0] w_cast_upd, w_votes_upd;
   logic                w_all_cast;

   btn_edge_det #(.W(N_VOTERS)) u_yes_edge (
      .clk    (clk),
      .rst    (rst),
      .i_lvl  (btn_yes_i),
      .o_rise (w_yes_rise)
   );

   btn_edge_det #(.W(N_VOTERS)) u_no_edge (
      .clk    (clk),
      .rst    (rst),
      .i_lvl  (btn_no_i),
      .o_rise (w_no_rise)
   );

   // A press counts only if the opposite button is released, so simultaneous yes+no cancels.
   assign w_yes_ok = w_yes_rise & ~btn_no_i;
   assign w_no_ok  = w_no_rise  & ~btn_yes_i;

`ifdef REVOTE_EN
   assign w_rec      = w_yes_ok | w_no_ok;
   assign w_all_cast = 1'b0;
`else
   assign w_rec      = (w_yes_ok | w_no_ok) & ~r_cast;
   assign w_all_cast = &w_cast_upd;
`endif

   assign w_cast_upd  = r_cast | w_rec;
   assign w_votes_upd = (r_votes & ~w_rec) | (w_yes_ok & w_rec);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_votes   <= '0;
         r_cast    <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_votes   <= w_votes_nxt;
         r_cast    <= w_cast_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_votes_nxt   = r_votes;
      w_cast_nxt    = r_cast;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = r_timeout;
      unique case (r_state)
         IDLE, DONE: begin
            if (start_i) begin
               w_state_nxt   = OPEN;
               w_votes_nxt   = '0;
               w_cast_nxt    = '0;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b0;
            end
         end
         OPEN: begin
            w_votes_nxt = w_votes_upd;
            w_cast_nxt  = w_cast_upd;
            w_cnt_nxt   = r_cnt + 1'b1;
            // Voluntary closes take precedence over the timeout on the same edge.
            if (w_all_cast || close_i) begin
               w_state_nxt = DONE;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt   = DONE;
               w_timeout_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign votes_o   = r_votes;
   assign cast_o    = r_cast;
   assign open_o    = (r_state == OPEN);
   assign valid_o   = (r_state == DONE);
   assign timeout_o = r_timeout;

endmodule
